// File: rtl/register_scoreboard_pkg.sv
// ============================================================================
// register_scoreboard_pkg: usage-flag bit positions and writeback file codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package register_scoreboard_pkg;

    // Bit order of the decode table's 10-bit usage word, MSB first.
    localparam int USE_W          = 10;
    localparam int USE_D_FROM_GPR = 9;
    localparam int USE_D_FROM_FPR = 8;
    localparam int USE_D_TO_GPR   = 7;
    localparam int USE_D_TO_FPR   = 6;
    localparam int USE_S_FROM_GPR = 5;
    localparam int USE_S_FROM_FPR = 4;
    localparam int USE_T_FROM_GPR = 3;
    localparam int USE_T_FROM_FPR = 2;
    localparam int USE_FROM_FCOND = 1;
    localparam int USE_TO_FCOND   = 0;

    localparam logic [1:0] WBF_GPR = 2'b00;
    localparam logic [1:0] WBF_FPR = 2'b01;
    localparam logic [1:0] WBF_FC  = 2'b10;
    localparam logic [1:0] WBF_BAD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/register_scoreboard_pending_file.sv
// ============================================================================
// register_scoreboard_pending_file: pending-bit vector of one register file
// with bypass-aware lookups. Option macro: SCOREBOARD_WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_scoreboard_pending_file #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int NUM_RD = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_valid_i,
    input  logic [IDX_W-1:0]        set_idx_i,
    input  logic [DEPTH-1:0]        clr_vec_i,
    input  logic [NUM_RD*IDX_W-1:0] rd_idx_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    output logic [NUM_RD-1:0]       rd_busy_o,
    output logic                    wr_busy_o,
    output logic [DEPTH-1:0]        pending_o,
    output logic [DEPTH-1:0]        pending_d_o
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [DEPTH-1:0] w_set_vec;
    logic [DEPTH-1:0] w_eff;

    always_comb begin
        w_set_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (set_valid_i && (set_idx_i == IDX_W'(i))) begin
                w_set_vec[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_vec_i) | w_set_vec;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_eff = pending_q & ~clr_vec_i;
`else
    assign w_eff = pending_q;
`endif

    // Indices at or beyond DEPTH match no entry and so never report busy.
    always_comb begin
        rd_busy_o = '0;
        wr_busy_o = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_idx_i[r*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    rd_busy_o[r] = w_eff[i];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx_i == IDX_W'(i)) begin
                wr_busy_o = w_eff[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o   = pending_q;
    assign pending_d_o = pending_d;

endmodule

`default_nettype wire

// File: rtl/register_scoreboard.sv
// ============================================================================
// register_scoreboard: RAW/WAW hazard scoreboard for decode/issue with
// NUM_WB release ports. Option macro: SCOREBOARD_WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int NUM_GPR  = 32,
    parameter int NUM_FPR  = 32,
    parameter int REG_W    = 5,
    parameter int NUM_WB   = 2,
    parameter int GPR_ZERO = 1,
    localparam int OUT_W   = $clog2(NUM_GPR + NUM_FPR + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid_i,
    output logic                    iss_ready_o,
    input  logic [USE_W-1:0]        iss_use_i,
    input  logic [REG_W-1:0]        iss_rd_i,
    input  logic [REG_W-1:0]        iss_rs_i,
    input  logic [REG_W-1:0]        iss_rt_i,
    input  logic [NUM_WB-1:0]       wb_valid_i,
    input  logic [2*NUM_WB-1:0]     wb_file_i,
    input  logic [REG_W*NUM_WB-1:0] wb_idx_i,
    output logic [NUM_GPR-1:0]      gpr_pending_o,
    output logic [NUM_FPR-1:0]      fpr_pending_o,
    output logic                    fc_pending_o,
    output logic [OUT_W-1:0]        outstanding_o,
    output logic                    wb_err_o
);

    logic [NUM_GPR-1:0] w_clr_gpr, w_gpr_d;
    logic [NUM_FPR-1:0] w_clr_fpr, w_fpr_d;
    logic [0:0]         w_clr_fc, w_fc_d, w_fc_rd_busy;
    logic [2:0]         w_gpr_rd_busy, w_fpr_rd_busy;
    logic               w_gpr_wr_busy, w_fpr_wr_busy, w_fc_wr_busy;
    logic               w_fire, w_set_gpr, w_set_fpr, w_set_fc;
    logic               w_rd_haz, w_wr_haz, w_err_now, w_hit;
    logic [1:0]         w_file;
    logic [REG_W-1:0]   w_idx;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               wb_err_q, wb_err_d;

    // Release decode; a hit means the addressed bit is pending in the registered state.
    always_comb begin
        w_clr_gpr = '0;
        w_clr_fpr = '0;
        w_clr_fc  = '0;
        w_err_now = 1'b0;
        w_hit     = 1'b0;
        w_file    = '0;
        w_idx     = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            w_file = wb_file_i[2*p +: 2];
            w_idx  = wb_idx_i[REG_W*p +: REG_W];
            w_hit  = 1'b0;
            if (wb_valid_i[p]) begin
                case (w_file)
                    WBF_GPR: begin
                        for (int i = 0; i < NUM_GPR; i++) begin
                            if (w_idx == REG_W'(i)) begin
                                w_clr_gpr[i] = 1'b1;
                                w_hit        = gpr_pending_o[i];
                            end
                        end
                    end
                    WBF_FPR: begin
                        for (int i = 0; i < NUM_FPR; i++) begin
                            if (w_idx == REG_W'(i)) begin
                                w_clr_fpr[i] = 1'b1;
                                w_hit        = fpr_pending_o[i];
                            end
                        end
                    end
                    WBF_FC: begin
                        w_clr_fc = 1'b1;
                        w_hit    = fc_pending_o;
                    end
                    default: w_hit = 1'b0;
                endcase
                if (!w_hit) begin
                    w_err_now = 1'b1;
                end
            end
        end
    end

    assign w_rd_haz = (iss_use_i[USE_D_FROM_GPR] & w_gpr_rd_busy[0])
                    | (iss_use_i[USE_D_FROM_FPR] & w_fpr_rd_busy[0])
                    | (iss_use_i[USE_S_FROM_GPR] & w_gpr_rd_busy[1])
                    | (iss_use_i[USE_S_FROM_FPR] & w_fpr_rd_busy[1])
                    | (iss_use_i[USE_T_FROM_GPR] & w_gpr_rd_busy[2])
                    | (iss_use_i[USE_T_FROM_FPR] & w_fpr_rd_busy[2])
                    | (iss_use_i[USE_FROM_FCOND] & w_fc_rd_busy[0]);

    assign w_wr_haz = (iss_use_i[USE_D_TO_GPR] & w_gpr_wr_busy)
                    | (iss_use_i[USE_D_TO_FPR] & w_fpr_wr_busy)
                    | (iss_use_i[USE_TO_FCOND] & w_fc_wr_busy);

    assign iss_ready_o = ~(w_rd_haz | w_wr_haz);
    assign w_fire      = iss_valid_i & iss_ready_o;
    assign w_set_gpr   = w_fire & iss_use_i[USE_D_TO_GPR]
                       & ~((GPR_ZERO != 0) && (iss_rd_i == '0));
    assign w_set_fpr   = w_fire & iss_use_i[USE_D_TO_FPR];
    assign w_set_fc    = w_fire & iss_use_i[USE_TO_FCOND];

    register_scoreboard_pending_file #(.DEPTH(NUM_GPR), .IDX_W(REG_W), .NUM_RD(3)) u_gpr (
        .clk(clk), .rst(rst),
        .set_valid_i(w_set_gpr), .set_idx_i(iss_rd_i), .clr_vec_i(w_clr_gpr),
        .rd_idx_i({iss_rt_i, iss_rs_i, iss_rd_i}), .wr_idx_i(iss_rd_i),
        .rd_busy_o(w_gpr_rd_busy), .wr_busy_o(w_gpr_wr_busy),
        .pending_o(gpr_pending_o), .pending_d_o(w_gpr_d)
    );

    register_scoreboard_pending_file #(.DEPTH(NUM_FPR), .IDX_W(REG_W), .NUM_RD(3)) u_fpr (
        .clk(clk), .rst(rst),
        .set_valid_i(w_set_fpr), .set_idx_i(iss_rd_i), .clr_vec_i(w_clr_fpr),
        .rd_idx_i({iss_rt_i, iss_rs_i, iss_rd_i}), .wr_idx_i(iss_rd_i),
        .rd_busy_o(w_fpr_rd_busy), .wr_busy_o(w_fpr_wr_busy),
        .pending_o(fpr_pending_o), .pending_d_o(w_fpr_d)
    );

    register_scoreboard_pending_file #(.DEPTH(1), .IDX_W(1), .NUM_RD(1)) u_fc (
        .clk(clk), .rst(rst),
        .set_valid_i(w_set_fc), .set_idx_i(1'b0), .clr_vec_i(w_clr_fc),
        .rd_idx_i(1'b0), .wr_idx_i(1'b0),
        .rd_busy_o(w_fc_rd_busy), .wr_busy_o(w_fc_wr_busy),
        .pending_o(fc_pending_o), .pending_d_o(w_fc_d)
    );

    always_comb begin
        outstanding_d = OUT_W'(w_fc_d[0]);
        for (int i = 0; i < NUM_GPR; i++) begin
            outstanding_d = outstanding_d + OUT_W'(w_gpr_d[i]);
        end
        for (int i = 0; i < NUM_FPR; i++) begin
            outstanding_d = outstanding_d + OUT_W'(w_fpr_d[i]);
        end
        wb_err_d = wb_err_q | w_err_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign wb_err_o      = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_register_scoreboard.sv
// ============================================================================
// tb_register_scoreboard: directed + random stimulus against a set-based
// reference model of the scoreboard. Honours SCOREBOARD_WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_scoreboard;

    localparam int NG = 32;
    localparam int NF = 32;
    localparam int RW = 5;
    localparam int NW = 2;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [9:0] U_DFG = 10'b10_0000_0000;
    localparam logic [9:0] U_DTG = 10'b00_1000_0000;
    localparam logic [9:0] U_DTF = 10'b00_0100_0000;
    localparam logic [9:0] U_SFG = 10'b00_0010_0000;
    localparam logic [9:0] U_SFF = 10'b00_0001_0000;
    localparam logic [9:0] U_TFG = 10'b00_0000_1000;
    localparam logic [9:0] U_TFF = 10'b00_0000_0100;
    localparam logic [9:0] U_FFC = 10'b00_0000_0010;
    localparam logic [9:0] U_TFC = 10'b00_0000_0001;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            iss_valid_i = 1'b0;
    logic            iss_ready_o;
    logic [9:0]      iss_use_i = '0;
    logic [RW-1:0]   iss_rd_i = '0, iss_rs_i = '0, iss_rt_i = '0;
    logic [NW-1:0]   wb_valid_i = '0;
    logic [2*NW-1:0] wb_file_i = '0;
    logic [RW*NW-1:0] wb_idx_i = '0;
    logic [NG-1:0]   gpr_pending_o;
    logic [NF-1:0]   fpr_pending_o;
    logic            fc_pending_o;
    logic [6:0]      outstanding_o;
    logic            wb_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain sets of in-flight destinations.
    bit m_gpr[NG];
    bit m_fpr[NF];
    bit m_fc, m_err;
    bit rl_gpr[NG];
    bit rl_fpr[NF];
    bit rl_fc;

    always #5 clk = ~clk;

    register_scoreboard dut (
        .clk(clk), .rst(rst),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_use_i(iss_use_i),
        .iss_rd_i(iss_rd_i), .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i),
        .wb_valid_i(wb_valid_i), .wb_file_i(wb_file_i), .wb_idx_i(wb_idx_i),
        .gpr_pending_o(gpr_pending_o), .fpr_pending_o(fpr_pending_o),
        .fc_pending_o(fc_pending_o), .outstanding_o(outstanding_o), .wb_err_o(wb_err_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy(input int f, input int idx);
        case (f)
            0:       return (idx < NG) && m_gpr[idx] && !(BYP && rl_gpr[idx]);
            1:       return (idx < NF) && m_fpr[idx] && !(BYP && rl_fpr[idx]);
            default: return m_fc && !(BYP && rl_fc);
        endcase
    endfunction

    task automatic check_state();
        logic [NG-1:0] eg;
        logic [NF-1:0] ef;
        int cnt;
        cnt = int'(m_fc);
        for (int i = 0; i < NG; i++) begin eg[i] = m_gpr[i]; cnt += int'(m_gpr[i]); end
        for (int i = 0; i < NF; i++) begin ef[i] = m_fpr[i]; cnt += int'(m_fpr[i]); end
        check_val("gpr_pending", gpr_pending_o, eg);
        check_val("fpr_pending", fpr_pending_o, ef);
        check_val("fc_pending", fc_pending_o, m_fc);
        check_val("outstanding", outstanding_o, cnt);
        check_val("wb_err", wb_err_o, m_err);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input bit v, input logic [9:0] u, input int rd, input int rs, input int rt,
                       input logic [1:0] wv, input int wf0, input int wi0, input int wf1, input int wi1);
        bit err, ready;
        iss_valid_i = v;
        iss_use_i   = u;
        iss_rd_i    = RW'(rd);
        iss_rs_i    = RW'(rs);
        iss_rt_i    = RW'(rt);
        wb_valid_i  = wv;
        wb_file_i   = {2'(wf1), 2'(wf0)};
        wb_idx_i    = {RW'(wi1), RW'(wi0)};
        rl_gpr = '{default: 1'b0};
        rl_fpr = '{default: 1'b0};
        rl_fc  = 1'b0;
        err    = 1'b0;
        for (int p = 0; p < NW; p++) begin
            int f, ix;
            f  = (p == 0) ? wf0 : wf1;
            ix = (p == 0) ? wi0 : wi1;
            if (wv[p]) begin
                if (f == 0) begin
                    if (ix < NG) begin err |= !m_gpr[ix]; rl_gpr[ix] = 1'b1; end else err = 1'b1;
                end else if (f == 1) begin
                    if (ix < NF) begin err |= !m_fpr[ix]; rl_fpr[ix] = 1'b1; end else err = 1'b1;
                end else if (f == 2) begin
                    err |= !m_fc; rl_fc = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
        end
        ready = !((u[9] && busy(0, rd)) || (u[8] && busy(1, rd)) ||
                  (u[5] && busy(0, rs)) || (u[4] && busy(1, rs)) ||
                  (u[3] && busy(0, rt)) || (u[2] && busy(1, rt)) ||
                  (u[1] && busy(2, 0))  ||
                  (u[7] && busy(0, rd)) || (u[6] && busy(1, rd)) || (u[0] && busy(2, 0)));
        #1;
        check_val("iss_ready", iss_ready_o, ready);
        @(posedge clk);
        for (int i = 0; i < NG; i++) if (rl_gpr[i]) m_gpr[i] = 1'b0;
        for (int i = 0; i < NF; i++) if (rl_fpr[i]) m_fpr[i] = 1'b0;
        if (rl_fc) m_fc = 1'b0;
        if (v && ready) begin
            if (u[7] && rd < NG && rd != 0) m_gpr[rd] = 1'b1;
            if (u[6] && rd < NF) m_fpr[rd] = 1'b1;
            if (u[0]) m_fc = 1'b1;
        end
        m_err |= err;
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        cyc(1'b0, '0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        iss_valid_i = 1'b0;
        wb_valid_i  = '0;
        rst = 1'b1;
        #1;
        check_val("rst_gpr", gpr_pending_o, 0);
        check_val("rst_fpr", fpr_pending_o, 0);
        check_val("rst_fc", fc_pending_o, 0);
        check_val("rst_outstanding", outstanding_o, 0);
        check_val("rst_wb_err", wb_err_o, 0);
        check_val("rst_ready", iss_ready_o, 1);
        m_gpr = '{default: 1'b0};
        m_fpr = '{default: 1'b0};
        m_fc  = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // ADDI rd=5, then a dependant ADD reading rs=5.
        cyc(1, U_DTG | U_SFG, 5, 1, 0, 2'b00, 0, 0, 0, 0);
        check_val("addi_pend5", gpr_pending_o[5], 1);
        check_val("addi_outst", outstanding_o, 1);
        cyc(1, U_DTG | U_SFG | U_TFG, 6, 5, 2, 2'b00, 0, 0, 0, 0);
        check_val("add_stall", iss_ready_o, 0);
        cyc(1, U_DTG | U_SFG | U_TFG, 6, 5, 2, 2'b01, 0, 5, 0, 0);
        check_val("wb_same_cycle_fire", gpr_pending_o[6], BYP);
        cyc(1, U_DTG | U_SFG | U_TFG, 6, 5, 2, 2'b00, 0, 0, 0, 0);

        // Mid-stream reset with gpr 5 and fc pending.
        cyc(1, U_DTG, 5, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, U_TFC, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_reset();

        // FCLT pending, BC1T waits, second FCLT stalls on WAW, WB fcond on port 1.
        cyc(1, U_TFC | U_SFF | U_TFF, 0, 1, 2, 2'b00, 0, 0, 0, 0);
        cyc(1, U_FFC, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_val("bc1t_stall", iss_ready_o, 0);
        cyc(1, U_TFC, 0, 1, 2, 2'b00, 0, 0, 0, 0);
        check_val("fclt_waw", iss_ready_o, 0);
        cyc(1, U_FFC, 0, 0, 0, 2'b10, 0, 0, 2, 0);
        cyc(1, U_FFC, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // GPR 0 is never tracked.
        cyc(1, U_DTG, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_val("gpr0_not_set", gpr_pending_o, 0);
        cyc(1, U_DFG | U_SFG | U_TFG, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_val("gpr0_read_ok", iss_ready_o, 1);

        // Dual release of one pending bit is legal; release of an idle one is not.
        cyc(1, U_DTF, 3, 0, 0, 2'b00, 0, 0, 0, 0);
        check_val("fpr3_set", fpr_pending_o[3], 1);
        cyc(0, '0, 0, 0, 0, 2'b11, 1, 3, 1, 3);
        check_val("dual_clr_no_err", wb_err_o, 0);
        check_val("dual_clr_fpr3", fpr_pending_o[3], 0);
        cyc(0, '0, 0, 0, 0, 2'b01, 1, 7, 0, 0);
        check_val("fpr7_err", wb_err_o, 1);
        idle();
        check_val("err_sticky", wb_err_o, 1);

        // Random traffic over a narrow index window to provoke hazards.
        for (int k = 0; k < 600; k++) begin
            logic [1:0] wv;
            if (k % 100 == 0) do_reset();
            wv[0] = ($urandom_range(0, 2) == 0);
            wv[1] = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 3) != 0, 10'($urandom),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), wv,
                ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2), $urandom_range(0, 7),
                ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2), $urandom_range(0, 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
